// File: rtl/chess_clock_arbiter_if.sv
// Signal bundle between the chess clock arbiter and its button/counter
// front-end. The master side drives the pulses and levels; the slave side is the arbiter.
interface chess_clock_arbiter_if;
    // i_start, i_pause and i_turn are single-cycle pulses and i_zero is a level.
    // All of them are sampled on the rising clock edge. There is no back-pressure.
    // Every o_* signal is registered, so it changes one cycle after the input that caused it.
    logic             i_start;
    logic             i_pause;
    logic [1:0][3:0]  i_cfg;
    logic [1:0]       i_turn;
    logic [1:0]       i_zero;
    logic [1:0]       o_restart;
    logic [1:0][3:0]  o_init;
    logic [1:0]       o_stop;
    logic [1:0]       o_win;
    logic [1:0][3:0]  o_moves;
    logic [2:0]       o_state;

    modport master (
        output i_start, i_pause, i_cfg, i_turn, i_zero,
        input  o_restart, o_init, o_stop, o_win, o_moves, o_state
    );

    modport slave (
        input  i_start, i_pause, i_cfg, i_turn, i_zero,
        output o_restart, o_init, o_stop, o_win, o_moves, o_state
    );
endinterface

// File: rtl/chess_clock_arbiter.sv
// Two-player chess clock arbiter: decides whose counter runs, handles pause,
// game over and abort, and keeps the BCD count of completed full moves.
module chess_clock_arbiter #(
    parameter int p_first = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    chess_clock_arbiter_if.slave  bus
);

    typedef enum logic [2:0] {
        st_idle  = 3'd0,
        st_run0  = 3'd1,
        st_run1  = 3'd2,
        st_pause = 3'd3,
        st_over  = 3'd4
    } state_t;

    localparam logic   first_bit   = (p_first != 0);
    localparam state_t first_state = first_bit ? st_run1 : st_run0;

    state_t           state_q, state_d;
    logic             resume_q, resume_d;
    logic [1:0]       win_q, win_d;
    logic [1:0][3:0]  moves_q, moves_d;
    logic [1:0][3:0]  init_q, init_d;
    logic             player;
    logic [1:0]       restart;
    logic [1:0]       stop;

    // In a RUN state, this is the index of the player whose clock is running.
    assign player = (state_q == st_run1);

    function automatic logic [1:0][3:0] bcd_inc(input logic [1:0][3:0] v);
        logic [1:0][3:0] r;
        r = v;
        if (v[0] == 4'd9) begin
            r[0] = 4'd0;
            r[1] = (v[1] == 4'd9) ? 4'd0 : v[1] + 4'd1;
        end else begin
            r[0] = v[0] + 4'd1;
        end
        return r;
    endfunction

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q  <= st_idle;
            resume_q <= 1'b0;
            win_q    <= 2'b00;
            moves_q  <= '0;
            init_q   <= '0;
        end else begin
            state_q  <= state_d;
            resume_q <= resume_d;
            win_q    <= win_d;
            moves_q  <= moves_d;
            init_q   <= init_d;
        end
    end

    // Priority among events that arrive together: start, then zero, then pause, then turn.
    always_comb begin
        state_d  = state_q;
        resume_d = resume_q;
        win_d    = win_q;
        moves_d  = moves_q;
        init_d   = init_q;
        case (state_q)
            st_idle: begin
                init_d  = bus.i_cfg;
                win_d   = 2'b00;
                moves_d = '0;
                if (bus.i_start) state_d = first_state;
            end
            st_run0, st_run1: begin
                win_d = 2'b00;
                if (bus.i_start) begin
                    state_d = st_idle;
                end else if (bus.i_zero[player]) begin
                    state_d = st_over;
                    win_d   = player ? 2'b01 : 2'b10;
                end else if (bus.i_pause) begin
                    state_d  = st_pause;
                    resume_d = player;
                end else if (bus.i_turn[player]) begin
                    state_d = player ? st_run0 : st_run1;
                    // A full move is finished when the second player to move clicks.
                    if (player != first_bit) moves_d = bcd_inc(moves_q);
                end
            end
            st_pause: begin
                if (bus.i_start)      state_d = st_idle;
                else if (bus.i_pause) state_d = resume_q ? st_run1 : st_run0;
            end
            st_over: begin
                if (bus.i_start) state_d = st_idle;
            end
            default: state_d = st_idle;
        endcase
        if (state_d == st_idle) begin
            moves_d = '0;
            win_d   = 2'b00;
        end
    end

    always_comb begin
        restart = 2'b11;
        stop    = 2'b11;
        case (state_q)
            st_run0: begin
                restart = 2'b00;
                stop    = 2'b10;
            end
            st_run1: begin
                restart = 2'b00;
                stop    = 2'b01;
            end
            st_pause, st_over: begin
                restart = 2'b00;
                stop    = 2'b11;
            end
            default: begin
                restart = 2'b11;
                stop    = 2'b11;
            end
        endcase
    end

    assign bus.o_restart = restart;
    assign bus.o_stop    = stop;
    assign bus.o_win     = win_q;
    assign bus.o_moves   = moves_q;
    assign bus.o_init    = init_q;
    assign bus.o_state   = state_q;

endmodule

// File: doc/chess_clock_arbiter.md
CHESS_CLOCK_ARBITER -- requirements
Module: chess_clock_arbiter

Interface
REQ-001 SHALL have parameter p_first, default 0, meaning index (0/1) of the player whose clock runs first.
REQ-002 SHALL have port i_clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_start  input  1  one-cycle pulse from start/reset button driver.
REQ-005 SHALL have port i_pause  input  1  one-cycle pulse, pause/resume toggle.
REQ-006 SHALL have port i_cfg  input  [3:0][1:0]  initial time, two BCD digits ([1]=tens, [0]=units).
REQ-007 SHALL have port i_turn  input  [1:0]  per-player one-cycle "turn done" click pulse.
REQ-008 SHALL have port i_zero  input  [1:0]  per-player "counter reached 00" level.
REQ-009 SHALL have port o_restart  output  [1:0]  per-player counter/divider reload, active-high.
REQ-010 SHALL have port o_init  output  [3:0][1:0]  BCD initial time shared by both players.
REQ-011 SHALL have port o_stop  output  [1:0]  per-player clock freeze, active-high.
REQ-012 SHALL have port o_win  output  [1:0]  one-hot winner indication.
REQ-013 SHALL have port o_moves  output  [3:0][1:0]  BCD completed-move count 00..99.
REQ-014 SHALL have port o_state  output  3  state code: IDLE=0, RUN0=1, RUN1=2, PAUSE=3, OVER=4.

Function
REQ-015 SHALL implement a Moore FSM with states IDLE, RUN0, RUN1, PAUSE, OVER; all outputs derive from registers only, so a response appears exactly one i_clk cycle after the sampled input.
REQ-016 IDLE: o_restart=11, o_stop=11, o_win=00, o_moves=00; o_init register loads i_cfg every cycle.
REQ-017 o_init SHALL hold its value in every state except IDLE.
REQ-018 IDLE + i_start -> RUN0 if p_first=0, else RUN1.
REQ-019 RUNn: o_restart=00, o_stop has bit n cleared and the other bit set, o_win=00.
REQ-020 RUNn + i_turn[n] -> RUN(1-n); i_turn of the stopped player SHALL be ignored.
REQ-021 RUNn + i_zero[n] -> OVER with winner = player 1-n; i_zero of the stopped player SHALL be ignored.
REQ-022 RUNn + i_pause -> PAUSE, remembering n in a resume register.
REQ-023 PAUSE: o_stop=11, o_restart=00; i_turn and i_zero ignored; i_pause -> RUN(resume register).
REQ-024 OVER: o_stop=11, o_restart=00 (displays keep final values), o_win one-hot for the winner; i_turn, i_zero, i_pause ignored.
REQ-025 i_start in any of RUN0, RUN1, PAUSE or OVER -> IDLE (abort/new game).
REQ-026 Simultaneous events priority: i_start > i_zero > i_pause > i_turn.
REQ-027 o_moves SHALL increment by one in BCD on each accepted i_turn of the player other than p_first, i.e. a full move. Units 9 -> 0 with tens carry; 99 -> 00 wrap.
REQ-028 o_moves SHALL clear to 00 on entry to IDLE and hold in PAUSE and OVER.
REQ-029 i_cfg = 00: the first RUN state sees i_zero set and SHALL go to OVER on the next cycle.
REQ-030 Undefined state codes SHALL recover to IDLE on the next clock.

Reset
REQ-031 i_rst low SHALL immediately force IDLE, o_restart=11, o_stop=11, o_win=00, o_moves=00, o_init=00, resume register=0, o_state=0, regardless of i_clk.
REQ-032 Reset released mid-game SHALL leave the block in IDLE; no prior game state survives.

Verification
REQ-033 i_cfg=05, p_first=0, pulse i_start -> next cycle o_state=1, o_stop=10, o_restart=00, o_init=05.
REQ-034 RUN0: pulse i_turn[1] -> no change; pulse i_turn[0] -> RUN1 with o_stop=01, o_moves=00; then i_turn[1] -> RUN0 with o_moves=01.
REQ-035 RUN1: assert i_zero[1] together with i_turn[1] and i_pause -> OVER with o_win=01, o_stop=11.
REQ-036 RUN1: pulse i_pause -> PAUSE with o_stop=11; i_turn[1] ignored; pulse i_pause -> RUN1 with o_stop=01.
REQ-037 Preload 99 full moves, complete one more -> o_moves=00; pulse i_start in OVER -> IDLE with o_restart=11.
REQ-038 Assert i_rst low asynchronously between clock edges in RUN0 -> outputs reach reset values before the next i_clk edge.
